m2_deframer: RTL and testbench

- Receive side of the M2 telemetry serial stream, used in the imitator's loopback checker and as a ground-side receiver model.
- Recovers the slot timing from the incoming line and aligns to the phrase marker.
- Rebuilds each 24-slot bit-doubled word and emits the 12-bit parallel word, its position in the 4-word marker period, the raw marker pair and error flags.
- Same clock domain as the transmitter: 2 × 12,582,912 Hz, one serial slot every 4 clocks.

---
 rtl/m2_deframer_if.sv | 13 +
 rtl/m2_deframer.sv | 123 ++++++++++++
 tb/tb_m2_deframer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/m2_deframer_if.sv
// m2_deframer_if: serial line in, recovered word/status out of the M2 deframer.
interface m2_deframer_if;
  logic        iSerial;
  logic [11:0] oParallel;
  logic        oValid;
  logic [1:0]  oWordIdx;
  logic [1:0]  oMarker;
  logic        oPairErr;
  logic        oLock;
  logic        oLockLost;
  modport master (input iSerial, output oParallel, oValid, oWordIdx, oMarker, oPairErr, oLock, oLockLost);
  modport slave (output iSerial, input oParallel, oValid, oWordIdx, oMarker, oPairErr, oLock, oLockLost);
endinterface

// File: rtl/m2_deframer.sv
// m2_deframer: recovers slot timing, aligns to the M2 phrase marker and emits 12-bit words.
module m2_deframer #(
  parameter int DIV      = 4,
  parameter int CONFIRM  = 3,
  parameter int MISS_MAX = 2
) (
  input  logic          clk,
  input  logic          reset,
  m2_deframer_if.master bus
);
  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  typedef enum logic [1:0] {S_HUNT, S_CONFIRM, S_LOCKED} state_t;
  state_t        st_q, st_d;
  logic [2:0]    sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [22:0]   sr_q, sr_d;
  logic [4:0]    slot_q, slot_d, cur;
  logic [1:0]    wi_q, wi_d, idx_q, idx_d, mk_q, mk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [11:0]   par_q, par_d, dat, dif;
  logic          valid_q, valid_d, perr_q, perr_d, lost_q, lost_d;
  logic          edge_w, strobe, smp, wrap, mslot, last, perr_w;
  logic [23:0]   word;
  always_comb begin
    sync_d = {sync_q[1:0], bus.iSerial};
    smp = sync_q[1];
    edge_w = sync_q[1] ^ sync_q[2];
    // an edge restarts the divider so the strobe lands two clocks later, mid-slot
    strobe = div_q == DW'(1) && !edge_w;
    div_d = edge_w || div_q == DW'(DIV - 1) ? '0 : div_q + DW'(1);
    word = {sr_q, smp};
    dat = '0;
    dif = '0;
    for (int k = 0; k < 12; k++) begin
      dat[k] = word[2*k];
      dif[k] = word[2*k+1] ^ word[2*k];
    end
    perr_w = (|dif[10:0]) | (dif[11] & (wi_q != 2'd0));
    wrap = slot_q == 5'd0;
    cur = wrap ? 5'd23 : slot_q - 5'd1;
    mslot = wrap && wi_q == 2'd3;
    last = slot_q == 5'd1;
    st_d = st_q;
    sr_d = strobe ? word[22:0] : sr_q;
    slot_d = strobe ? cur : slot_q;
    wi_d = strobe && wrap ? wi_q + 2'd1 : wi_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    valid_d = 1'b0;
    lost_d = 1'b0;
    par_d = par_q;
    idx_d = idx_q;
    mk_d = mk_q;
    perr_d = perr_q;
    if (strobe && st_q == S_HUNT && sr_q[0] && !smp) begin
      st_d = S_CONFIRM;
      slot_d = 5'd22;
      wi_d = 2'd0;
      cnt_d = '0;
    end
    if (strobe && st_q == S_CONFIRM && mslot) begin
      cnt_d = cnt_q + CW'(1);
      st_d = !smp ? S_HUNT : cnt_d == CW'(CONFIRM) ? S_LOCKED : S_CONFIRM;
      miss_d = '0;
    end
    if (strobe && st_q == S_LOCKED) begin
      if (mslot) miss_d = smp ? '0 : miss_q + MW'(1);
      if (mslot && !smp && miss_d == MW'(MISS_MAX)) begin
        st_d = S_HUNT;
        lost_d = 1'b1;
      end else if (last) begin
        valid_d = 1'b1;
        par_d = dat;
        idx_d = wi_q;
        mk_d = word[23:22];
        perr_d = perr_w;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= S_HUNT;
      sync_q <= '0;
      div_q <= '0;
      sr_q <= '0;
      slot_q <= '0;
      wi_q <= '0;
      cnt_q <= '0;
      miss_q <= '0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
      par_q <= '0;
      idx_q <= '0;
      mk_q <= '0;
      perr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sync_q <= sync_d;
      div_q <= div_d;
      sr_q <= sr_d;
      slot_q <= slot_d;
      wi_q <= wi_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
      par_q <= par_d;
      idx_q <= idx_d;
      mk_q <= mk_d;
      perr_q <= perr_d;
    end
  end
  assign bus.oParallel = par_q;
  assign bus.oValid = valid_q;
  assign bus.oWordIdx = idx_q;
  assign bus.oMarker = mk_q;
  assign bus.oPairErr = perr_q;
  assign bus.oLock = st_q == S_LOCKED;
  assign bus.oLockLost = lost_q;
endmodule

// File: tb/tb_m2_deframer.sv
// tb_m2_deframer: directed M2 stream scenarios against hand-computed deframer outputs.
module tb_m2_deframer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  m2_deframer_if bus();
  m2_deframer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errs = 0, checks = 0, cyc = 0, valid_cnt = 0, lost_cnt = 0;
  int tx_idx = -1, tx_adj = 0, miss_n = 0;
  bit tx_go = 1'b0;
  logic [23:0] ovr [4];
  bit ovr_en [4];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.oValid) valid_cnt <= valid_cnt + 1;
    if (bus.oLockLost) lost_cnt <= lost_cnt + 1;
  end
  // transmitter: zero-data stream with marker word 0x800000, per-word overrides and a one-shot slot stretch
  initial begin
    logic [23:0] w;
    int n;
    bus.iSerial = 1'b0;
    wait (tx_go);
    forever begin
      tx_idx = (tx_idx + 1) % 4;
      w = tx_idx == 0 ? 24'h800000 : 24'h000000;
      if (tx_idx == 0 && miss_n > 0) begin w = 24'h000000; miss_n--; end
      if (ovr_en[tx_idx]) begin w = ovr[tx_idx]; ovr_en[tx_idx] = 1'b0; end
      for (int s = 23; s >= 0; s--) begin
        bus.iSerial = w[s];
        n = 4;
        if (s == 23 && tx_idx == 1) begin n = 4 + tx_adj; tx_adj = 0; end
        repeat (n) @(negedge clk);
      end
    end
  end
  task automatic sync_period;
    wait (tx_idx == 1);
    wait (tx_idx == 0);
  endtask
  task automatic wait_valid(input int idx, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(negedge clk);
      hit = bus.oValid && (idx < 0 || bus.oWordIdx == 2'(idx));
    end
    checks++;
    if (!hit) begin errs++; $display("FAIL %s: no oValid for idx %0d within 3000 clocks", name, idx); end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.oParallel, bus.oValid, bus.oWordIdx, bus.oMarker, bus.oPairErr, bus.oLock, bus.oLockLost} !== 20'h0) begin
      errs++; $display("FAIL reset_outputs: got par=%h v=%b idx=%0d mk=%b pe=%b lk=%b ll=%b, want all 0",
        bus.oParallel, bus.oValid, bus.oWordIdx, bus.oMarker, bus.oPairErr, bus.oLock, bus.oLockLost);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_acquire;
    tx_go = 1'b1;
    repeat (3 * 384 - 4) @(negedge clk);
    checks++;
    if (bus.oLock !== 1'b0) begin errs++; $display("FAIL lock_early: oLock=%b after 3 periods, want 0", bus.oLock); end
    checks++;
    if (valid_cnt != 0) begin errs++; $display("FAIL valid_before_lock: %0d pulses, want 0", valid_cnt); end
    repeat (384) @(negedge clk);
    checks++;
    if (bus.oLock !== 1'b1) begin errs++; $display("FAIL lock_rise: oLock=%b after 4 periods, want 1", bus.oLock); end
  endtask
  task automatic test_stream;
    int t;
    wait_valid(0, "stream_w0");
    t = cyc;
    checks++;
    if ({bus.oMarker, bus.oParallel, bus.oPairErr} !== {2'b10, 12'h000, 1'b0}) begin
      errs++; $display("FAIL stream_w0: mk=%b par=%h pe=%b, want mk=10 par=000 pe=0", bus.oMarker, bus.oParallel, bus.oPairErr);
    end
    for (int i = 1; i < 4; i++) begin
      wait_valid(-1, "stream_next");
      checks++;
      if (bus.oWordIdx !== 2'(i)) begin errs++; $display("FAIL stream_idx: idx=%0d, want %0d", bus.oWordIdx, i); end
      checks++;
      if ({bus.oMarker, bus.oParallel, bus.oPairErr} !== {2'b00, 12'h000, 1'b0}) begin
        errs++; $display("FAIL stream_word%0d: mk=%b par=%h pe=%b, want mk=00 par=000 pe=0", i, bus.oMarker, bus.oParallel, bus.oPairErr);
      end
      checks++;
      if (cyc - t != 96 * i) begin errs++; $display("FAIL stream_spacing: %0d clocks after word 0, want %0d", cyc - t, 96 * i); end
    end
  endtask
  task automatic test_data;
    sync_period();
    ovr[2] = 24'hCC33CC;
    ovr_en[2] = 1'b1;
    wait_valid(2, "data_wait");
    checks++;
    if ({bus.oParallel, bus.oMarker, bus.oPairErr} !== {12'hA5A, 2'b11, 1'b0}) begin
      errs++; $display("FAIL data_word: par=%h mk=%b pe=%b, want par=a5a mk=11 pe=0", bus.oParallel, bus.oMarker, bus.oPairErr);
    end
  endtask
  task automatic test_pair_err;
    sync_period();
    ovr[1] = 24'h000020;
    ovr_en[1] = 1'b1;
    wait_valid(1, "perr_wait");
    checks++;
    if ({bus.oPairErr, bus.oParallel, bus.oLock} !== {1'b1, 12'h000, 1'b1}) begin
      errs++; $display("FAIL perr_word: pe=%b par=%h lk=%b, want pe=1 par=000 lk=1", bus.oPairErr, bus.oParallel, bus.oLock);
    end
    wait_valid(2, "perr_after");
    checks++;
    if (bus.oPairErr !== 1'b0) begin errs++; $display("FAIL perr_clear: pe=%b on next word, want 0", bus.oPairErr); end
  endtask
  task automatic test_phase;
    int adj [3] = '{1, 2, -1};
    for (int i = 0; i < 3; i++) begin
      sync_period();
      tx_adj = adj[i];
      ovr[2] = 24'hCC33CC;
      ovr_en[2] = 1'b1;
      wait_valid(2, "phase_wait");
      checks++;
      if ({bus.oParallel, bus.oLock} !== {12'hA5A, 1'b1}) begin
        errs++; $display("FAIL phase_%0d: par=%h lk=%b, want par=a5a lk=1", adj[i], bus.oParallel, bus.oLock);
      end
      wait_valid(0, "phase_marker");
      checks++;
      if ({bus.oMarker, bus.oParallel} !== {2'b10, 12'h000}) begin
        errs++; $display("FAIL phase_marker_%0d: mk=%b par=%h, want mk=10 par=000", adj[i], bus.oMarker, bus.oParallel);
      end
    end
    checks++;
    if (lost_cnt != 0) begin errs++; $display("FAIL phase_lock: %0d lock losses, want 0", lost_cnt); end
  endtask
  task automatic test_single_miss;
    sync_period();
    miss_n = 1;
    wait_valid(0, "miss1_pre");
    wait_valid(0, "miss1_word");
    checks++;
    if ({bus.oMarker, bus.oPairErr, bus.oLock} !== {2'b00, 1'b0, 1'b1}) begin
      errs++; $display("FAIL miss1_word: mk=%b pe=%b lk=%b, want mk=00 pe=0 lk=1", bus.oMarker, bus.oPairErr, bus.oLock);
    end
    wait_valid(0, "miss1_recover");
    checks++;
    if ({bus.oMarker, bus.oLock} !== {2'b10, 1'b1} || lost_cnt != 0) begin
      errs++; $display("FAIL miss1_hold: mk=%b lk=%b losses=%0d, want mk=10 lk=1 losses=0", bus.oMarker, bus.oLock, lost_cnt);
    end
  endtask
  task automatic test_double_miss;
    int vc, t;
    bit hit = 1'b0;
    sync_period();
    miss_n = 2;
    for (int n = 0; n < 4 * 384 && !hit; n++) begin @(negedge clk); hit = bus.oLockLost; end
    checks++;
    if (!hit) begin errs++; $display("FAIL lost_pulse: oLockLost=0 after %0d clocks, want pulse", 4 * 384); end
    checks++;
    if (bus.oLock !== 1'b0) begin errs++; $display("FAIL lost_lock: oLock=%b at loss, want 0", bus.oLock); end
    vc = valid_cnt;
    t = cyc;
    hit = 1'b0;
    for (int n = 0; n < 6 * 384 && !hit; n++) begin @(negedge clk); hit = bus.oLock; end
    checks++;
    if (!hit) begin errs++; $display("FAIL relock: oLock=0 after %0d clocks, want 1", 6 * 384); end
    checks++;
    if (cyc - t < 4 * 384 - 4) begin errs++; $display("FAIL relock_time: %0d clocks, want >= %0d", cyc - t, 4 * 384 - 4); end
    checks++;
    if (valid_cnt != vc || lost_cnt != 1) begin
      errs++; $display("FAIL relock_quiet: valids=%0d losses=%0d, want valids=%0d losses=1", valid_cnt, lost_cnt, vc);
    end
  endtask
  task automatic test_reset_mid;
    int vc;
    bit hit = 1'b0;
    wait_valid(1, "rst_pre");
    repeat (40) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.oParallel, bus.oValid, bus.oWordIdx, bus.oMarker, bus.oPairErr, bus.oLock, bus.oLockLost} !== 20'h0) begin
      errs++; $display("FAIL rst_async: idx=%0d mk=%b lk=%b par=%h, want all 0", bus.oWordIdx, bus.oMarker, bus.oLock, bus.oParallel);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vc = valid_cnt;
    repeat (2 * 384) @(negedge clk);
    checks++;
    if (bus.oLock !== 1'b0) begin errs++; $display("FAIL rst_lock_early: oLock=%b 2 periods after reset, want 0", bus.oLock); end
    for (int n = 0; n < 5 * 384 && !hit; n++) begin @(negedge clk); hit = bus.oLock; end
    checks++;
    if (!hit || valid_cnt != vc || lost_cnt != 1) begin
      errs++; $display("FAIL rst_relock: lk=%b valids=%0d losses=%0d, want lk=1 valids=%0d losses=1", hit, valid_cnt, lost_cnt, vc);
    end
    wait_valid(0, "rst_resume");
    checks++;
    if ({bus.oMarker, bus.oParallel} !== {2'b10, 12'h000}) begin
      errs++; $display("FAIL rst_resume: mk=%b par=%h, want mk=10 par=000", bus.oMarker, bus.oParallel);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_acquire();
    test_stream();
    test_data();
    test_pair_err();
    test_phase();
    test_single_miss();
    test_double_miss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
